alu_md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide execute unit. It is the successor to the single-cycle combinational ALU in the pipeline EX stage.
- Implements the RV32M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Uses iterative shift-add multiplication and restoring division on operand magnitudes, with a valid/ready handshake on both sides.
- Carries a destination tag through so the hazard unit can stall EX and match writeback.

---
 rtl/alu_md_unit_pkg.sv | 47 ++++
 rtl/alu_md_unit_if.sv | 35 +++
 rtl/alu_md_unit_div_core.sv | 72 +++++++
 rtl/alu_md_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_alu_md_unit.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_md_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_md_unit_pkg
// Shared types and helpers for the RV32M multiply/divide execute unit.
//   md_op_e    : operation code, equal to the RV funct3 field
//   md_state_e : control FSM states (IDLE, BUSY, DONE)
//   op_*       : decode helpers for operand signedness and op class
// ---------------------------------------------------------------------------
package alu_md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // rs1 is signed for MULH, MULHSU, DIV and REM. MUL only returns the low
    // half, which is identical for signed and unsigned operands, so it is
    // treated as unsigned.
    function automatic logic op_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM only.
    function automatic logic op_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_md_unit_if.sv
// ---------------------------------------------------------------------------
// alu_md_unit_if
// Request/response handshake bundle of the multiply/divide unit.
//   request : in_valid, in_ready, in_op, in_a, in_b, in_tag
//   response: out_valid, out_ready, out_result, out_tag
// Modports:
//   master : the issuing side (EX stage / testbench)
//   slave  : the execute unit
// ---------------------------------------------------------------------------
interface alu_md_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/alu_md_unit_div_core.sv
// ---------------------------------------------------------------------------
// md_div_core
// Restoring divider datapath on unsigned magnitudes, one quotient bit per
// step. The quotient register starts out holding the dividend and shifts
// quotient bits in from the right as dividend bits leave on the left.
// Ports:
//   cpu_clk, cpu_rst : clock, asynchronous active-high reset
//   load             : capture dividend/divisor, clear partial remainder
//   step             : perform one shift-subtract iteration
//   dividend,divisor : unsigned magnitudes
//   quotient,remainder : valid after XLEN steps
// ---------------------------------------------------------------------------
module md_div_core #(
    parameter int XLEN = 32
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;

    // One extra bit so the shifted remainder never overflows before the
    // trial subtraction; a set MSB of the difference means "does not fit".
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr_q};

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        if (load) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvsr_d = divisor;
        end else if (step) begin
            if (diff[XLEN]) begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_md_unit.sv
// ---------------------------------------------------------------------------
// alu_md_unit
// Multi-cycle RV32M multiply/divide execute unit. Operands are reduced to
// magnitudes at accept; multiply uses an iterative shift-add (or a single
// combinational product when MUL_FAST=1), divide uses md_div_core. The
// result sign is applied once at the end.
// Ports:
//   cpu_clk, cpu_rst : clock, asynchronous active-high reset
//   md (slave)       : request/response handshake bundle
//   flush            : kill any in-flight operation, blocks accept in IDLE
//   busy             : high whenever the FSM is not IDLE (EX stall)
// Timing (accept at edge T):
//   iterative : XLEN step edges, then one sign-fixup edge -> DONE at T+XLEN+1
//   fast/special : precomputed at accept, DONE at T+1
// ---------------------------------------------------------------------------
module alu_md_unit
    import alu_md_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int MUL_FAST = 0
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    alu_md_unit_if.slave md,
    input  logic         flush,
    output logic         busy
);

    localparam int              CNT_W    = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_q, neg_d;
    logic             fast_q, fast_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    md_op_e          in_op;
    logic            in_ready;
    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            in_is_div, in_is_rem;
    logic            div_zero, div_ovf;
    logic            res_neg_in;
    logic            accept_fast;
    logic [XLEN-1:0] fast_mul_res;
    logic [XLEN-1:0] special_res;

    assign in_op     = md_op_e'(md.in_op);
    assign in_ready  = (state_q == ST_IDLE) && !flush;
    assign accept    = md.in_valid && in_ready;

    assign a_neg     = op_a_signed(in_op) && md.in_a[XLEN-1];
    assign b_neg     = op_b_signed(in_op) && md.in_b[XLEN-1];
    assign a_mag     = a_neg ? -md.in_a : md.in_a;
    assign b_mag     = b_neg ? -md.in_b : md.in_b;

    assign in_is_div = op_is_div(in_op);
    assign in_is_rem = op_is_rem(in_op);
    assign div_zero  = (md.in_b == '0);
    assign div_ovf   = in_is_div && op_b_signed(in_op) &&
                       (md.in_a == MOST_NEG) && (md.in_b == '1);

    // Remainder follows the dividend; product and quotient follow a XOR b.
    assign res_neg_in = in_is_rem ? a_neg : (a_neg ^ b_neg);

    generate
        if (MUL_FAST != 0) begin : g_fast_mul
            logic [2*XLEN-1:0] full_prod;
            logic [2*XLEN-1:0] signed_prod;
            assign full_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
            assign signed_prod = res_neg_in ? -full_prod : full_prod;
            assign fast_mul_res = (in_op == MD_MUL) ? signed_prod[XLEN-1:0]
                                                    : signed_prod[2*XLEN-1:XLEN];
        end else begin : g_iter_mul
            assign fast_mul_res = '0;
        end
    endgenerate

    // Divide-by-zero and signed overflow never enter the iterative loop.
    assign accept_fast = in_is_div ? (div_zero || div_ovf) : (MUL_FAST != 0);

    always_comb begin
        special_res = fast_mul_res;
        if (in_is_div) begin
            if (div_zero) begin
                special_res = in_is_rem ? md.in_a : '1;
            end else begin
                special_res = in_is_rem ? '0 : md.in_a;
            end
        end
    end

    // ------------------------------------------------------------------
    // Iterative multiply step: prod_q holds {partial high, remaining
    // multiplier bits}; each step conditionally adds the multiplicand into
    // the high half and shifts the whole register right by one.
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                       {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
    assign prod_step = {mul_sum, prod_q[XLEN-1:1]};

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    logic            div_load, div_step;
    logic [XLEN-1:0] div_quo, div_rem;

    md_div_core #(.XLEN(XLEN)) u_div (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // ------------------------------------------------------------------
    // Sign fixup of the finished magnitude result
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   mul_final, div_final, iter_final;

    assign prod_signed = neg_q ? -prod_q : prod_q;
    assign mul_final   = (op_q == MD_MUL) ? prod_signed[XLEN-1:0]
                                          : prod_signed[2*XLEN-1:XLEN];
    assign div_final   = op_is_rem(op_q) ? (neg_q ? -div_rem : div_rem)
                                         : (neg_q ? -div_quo : div_quo);
    assign iter_final  = op_is_div(op_q) ? div_final : mul_final;

    // ------------------------------------------------------------------
    // Control FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        tag_d        = tag_q;
        neg_d        = neg_q;
        fast_d       = fast_q;
        cnt_d        = cnt_q;
        prod_d       = prod_q;
        mcand_d      = mcand_q;
        res_d        = res_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        div_load     = 1'b0;
        div_step     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_BUSY;
                    op_d     = in_op;
                    tag_d    = md.in_tag;
                    neg_d    = res_neg_in;
                    fast_d   = accept_fast;
                    res_d    = special_res;
                    cnt_d    = '0;
                    prod_d   = {{XLEN{1'b0}}, a_mag};
                    mcand_d  = b_mag;
                    div_load = 1'b1;
                end
            end

            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (fast_q) begin
                    state_d      = ST_DONE;
                    out_result_d = res_q;
                    out_tag_d    = tag_q;
                end else if (cnt_q == CNT_LAST) begin
                    // All XLEN steps are in; this edge only applies the sign.
                    state_d      = ST_DONE;
                    out_result_d = iter_final;
                    out_tag_d    = tag_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_is_div(op_q)) begin
                        div_step = 1'b1;
                    end else begin
                        prod_d = prod_step;
                    end
                end
            end

            ST_DONE: begin
                if (flush || md.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q      <= ST_IDLE;
            op_q         <= MD_MUL;
            tag_q        <= '0;
            neg_q        <= 1'b0;
            fast_q       <= 1'b0;
            cnt_q        <= '0;
            prod_q       <= '0;
            mcand_q      <= '0;
            res_q        <= '0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            neg_q        <= neg_d;
            fast_q       <= fast_d;
            cnt_q        <= cnt_d;
            prod_q       <= prod_d;
            mcand_q      <= mcand_d;
            res_q        <= res_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign md.in_ready   = in_ready;
    assign md.out_valid  = (state_q == ST_DONE);
    assign md.out_result = out_result_q;
    assign md.out_tag    = out_tag_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_md_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_md_unit
// Drives an iterative (MUL_FAST=0) and a fast-multiply (MUL_FAST=1) instance
// with identical requests. Expected result, tag and latency are queued per
// instance at accept; per-instance monitors pop and compare on each transfer.
// ---------------------------------------------------------------------------
module tb_alu_md_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    always #5 cpu_clk = ~cpu_clk;

    logic             in_valid  = 1'b0;
    logic [2:0]       in_op     = '0;
    logic [XLEN-1:0]  in_a      = '0;
    logic [XLEN-1:0]  in_b      = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             flush     = 1'b0;
    logic             out_ready = 1'b1;
    logic             busy_it, busy_fa;
    bit               bp_hold   = 1'b0;
    bit               rnd_ready = 1'b0;

    alu_md_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) md_it ();
    alu_md_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) md_fa ();

    assign md_it.in_valid  = in_valid;
    assign md_it.in_op     = in_op;
    assign md_it.in_a      = in_a;
    assign md_it.in_b      = in_b;
    assign md_it.in_tag    = in_tag;
    assign md_it.out_ready = out_ready;
    assign md_fa.in_valid  = in_valid;
    assign md_fa.in_op     = in_op;
    assign md_fa.in_a      = in_a;
    assign md_fa.in_b      = in_b;
    assign md_fa.in_tag    = in_tag;
    assign md_fa.out_ready = out_ready;

    alu_md_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_FAST(0)) dut_it (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .md      (md_it),
        .flush   (flush),
        .busy    (busy_it)
    );

    alu_md_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_FAST(1)) dut_fa (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .md      (md_fa),
        .flush   (flush),
        .busy    (busy_fa)
    );

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t q_it[$];
    exp_t q_fa[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   seen_it = 1'b0, seen_fa = 1'b0;
    int   fcyc_it = 0, fcyc_fa = 0;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    // out_ready changes well clear of both clock edges.
    always @(posedge cpu_clk) begin
        #2;
        if (bp_hold)        out_ready = 1'b0;
        else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        else                out_ready = 1'b1;
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign/zero-extended operands and
    // the language's own truncating division and remainder.
    function automatic logic [XLEN-1:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb, r;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b};               return p[31:0];  end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};         return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};               return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                r = sa / sb;
                return r;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb;
                return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit fast_mul);
        bit special;
        special = op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        if (fast_mul && !op[2]) return 1;
        if (special) return 1;
        return XLEN + 1;
    endfunction

    task automatic mon_it();
        exp_t e;
        if (md_it.out_valid && !seen_it) begin seen_it = 1'b1; fcyc_it = cyc; end
        if (md_it.out_valid && out_ready) begin
            if (q_it.size() == 0) begin
                checks++; failures++;
                $display("FAIL it.unexpected_output actual=0x%08h required=none", md_it.out_result);
            end else begin
                e = q_it.pop_front();
                check("it.result", md_it.out_result, e.res);
                check("it.tag", 32'(md_it.out_tag), 32'(e.tag));
                check("it.latency", fcyc_it - e.acc, e.lat);
            end
            seen_it = 1'b0;
        end
    endtask

    task automatic mon_fa();
        exp_t e;
        if (md_fa.out_valid && !seen_fa) begin seen_fa = 1'b1; fcyc_fa = cyc; end
        if (md_fa.out_valid && out_ready) begin
            if (q_fa.size() == 0) begin
                checks++; failures++;
                $display("FAIL fa.unexpected_output actual=0x%08h required=none", md_fa.out_result);
            end else begin
                e = q_fa.pop_front();
                check("fa.result", md_fa.out_result, e.res);
                check("fa.tag", 32'(md_fa.out_tag), 32'(e.tag));
                check("fa.latency", fcyc_fa - e.acc, e.lat);
            end
            seen_fa = 1'b0;
        end
    endtask

    always @(negedge cpu_clk) begin
        if (cpu_rst) begin
            seen_it = 1'b0;
            seen_fa = 1'b0;
        end else begin
            mon_it();
            mon_fa();
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input bit push);
        int n;
        n = 0;
        @(negedge cpu_clk);
        while (!(md_it.in_ready && md_fa.in_ready) && n < 200) begin
            @(negedge cpu_clk);
            n++;
        end
        if (n >= 200) begin
            check("issue.wait_ready_timeout", 32'(n), 32'd0);
        end else begin
            in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
            @(posedge cpu_clk);
            #1;
            if (push) begin
                q_it.push_back('{model(op, a, b), tag, cyc, model_lat(op, a, b, 1'b0)});
                q_fa.push_back('{model(op, a, b), tag, cyc, model_lat(op, a, b, 1'b1)});
            end
            @(negedge cpu_clk);
            in_valid = 1'b0;
            in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
            $display("issue op=%0d a=0x%08h b=0x%08h tag=%0d exp=0x%08h", op, a, b, tag, model(op, a, b));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_it.size() != 0 || q_fa.size() != 0) && n < 400) begin
            @(negedge cpu_clk);
            n++;
        end
        if (n >= 400) check("drain.timeout", 32'(q_it.size() + q_fa.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int n;
        logic [31:0] e;

        // Reset values
        repeat (2) @(negedge cpu_clk);
        check("rst.in_ready", 32'(md_it.in_ready), 32'd1);
        check("rst.out_valid", 32'(md_it.out_valid | md_fa.out_valid), 32'd0);
        check("rst.busy", 32'(busy_it | busy_fa), 32'd0);
        check("rst.out_result", md_it.out_result | md_fa.out_result, 32'd0);
        check("rst.out_tag", 32'(md_it.out_tag | md_fa.out_tag), 32'd0);
        cpu_rst = 1'b0;

        // Iterative multiply with busy tracking
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b1);
        bad = 0;
        for (int i = 0; i < XLEN + 1; i++) begin
            if (!busy_it) bad++;
            @(negedge cpu_clk);
        end
        check("busy_during_mul", 32'(bad), 32'd0);
        drain();
        @(negedge cpu_clk);
        check("busy_after_mul", 32'(busy_it), 32'd0);

        // High multiplies
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b1); drain();
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1); drain();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1); drain();

        // Divides
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1); drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1); drain();
        issue(3'd5, 32'd100, 32'd7, 5'd7, 1'b1); drain();
        issue(3'd7, 32'd100, 32'd7, 5'd8, 1'b1); drain();

        // Special cases
        issue(3'd4, 32'd5, 32'd0, 5'd9, 1'b1); drain();
        issue(3'd6, 32'd5, 32'd0, 5'd10, 1'b1); drain();
        issue(3'd5, 32'd5, 32'd0, 5'd11, 1'b1); drain();
        issue(3'd7, 32'd5, 32'd0, 5'd12, 1'b1); drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1); drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1); drain();

        // Backpressure
        bp_hold = 1'b1;
        issue(3'd5, 32'd1000, 32'd7, 5'd21, 1'b1);
        e = model(3'd5, 32'd1000, 32'd7);
        n = 0;
        while (!md_it.out_valid && n < 100) begin @(negedge cpu_clk); n++; end
        check("bp.wait_valid", 32'(md_it.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp.result_held", md_it.out_result, e);
            check("bp.tag_held", 32'(md_it.out_tag), 32'd21);
            check("bp.in_ready_low", 32'(md_it.in_ready), 32'd0);
            @(negedge cpu_clk);
        end
        bp_hold = 1'b0;
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("bp.valid_dropped", 32'(md_it.out_valid), 32'd0);
        check("bp.in_ready_back", 32'(md_it.in_ready), 32'd1);
        check("bp.queue_empty", 32'(q_it.size()), 32'd0);

        // Flush at cycle 10 of a divide
        issue(3'd4, 32'd12345, 32'd77, 5'd15, 1'b0);
        repeat (9) @(negedge cpu_clk);
        flush = 1'b1;
        @(posedge cpu_clk);
        #1 flush = 1'b0;
        @(negedge cpu_clk);
        check("flush.in_ready", 32'(md_it.in_ready & md_fa.in_ready), 32'd1);
        check("flush.busy", 32'(busy_it | busy_fa), 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_it.out_valid || md_fa.out_valid) bad++;
            @(negedge cpu_clk);
        end
        check("flush.no_valid", 32'(bad), 32'd0);
        issue(3'd0, 32'd3, 32'd4, 5'd16, 1'b1); drain();

        // Asynchronous reset in the middle of BUSY
        issue(3'd5, 32'd999, 32'd10, 5'd17, 1'b0);
        repeat (5) @(negedge cpu_clk);
        #2 cpu_rst = 1'b1;
        #1;
        check("midrst.in_ready", 32'(md_it.in_ready & md_fa.in_ready), 32'd1);
        check("midrst.out_valid", 32'(md_it.out_valid | md_fa.out_valid), 32'd0);
        check("midrst.busy", 32'(busy_it | busy_fa), 32'd0);
        check("midrst.out_result", md_it.out_result | md_fa.out_result, 32'd0);
        check("midrst.out_tag", 32'(md_it.out_tag | md_fa.out_tag), 32'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // Randomized traffic with random consumer stalls
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'b1);
        end
        drain();
        rnd_ready = 1'b0;
        repeat (3) @(negedge cpu_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
